// File: rtl/axi_stream_remove_header.sv
// -----------------------------------------------------------------------------
// axi_stream_remove_header
//
// Strips a per-packet, runtime-selected number of leading bytes from each
// AXI-Stream packet and repacks the remaining bytes into full, MSB-aligned
// beats. Byte order is MSB-first: data[DATA_WD-1 -: 8] is the first byte of a
// beat, and the keep of the last beat is MSB-contiguous. The output stage is
// one register deep and sustains one beat per clock.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   valid_in, data_in, keep_in, last_in, ready_in
//                    input stream (keep_in all ones except on the last beat)
//   valid_out, data_out, keep_out, last_out, ready_out
//                    registered output stream; bytes with keep_out=0 are 0
//   valid_remove, byte_remove_cnt, ready_remove
//                    one request per packet: bytes to strip, 0..DATA_BYTE_WD
//   err_keep         only when AXIS_REMOVE_HDR_CHECK_EN is defined: one-clock
//                    pulse on an accepted beat with a malformed keep_in
//
// Configuration macro: AXIS_REMOVE_HDR_CHECK_EN
// -----------------------------------------------------------------------------
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD:0]    byte_remove_cnt,
    output logic                    ready_remove
`ifdef AXIS_REMOVE_HDR_CHECK_EN
    ,
    output logic                    err_keep
`endif
);

    // Byte counts up to 2*DATA_BYTE_WD-1 (residue plus a full beat)
    localparam int TOT_WD = BYTE_CNT_WD + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    function automatic logic [TOT_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
        logic [TOT_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + TOT_WD'(k[i]);
        end
        return c;
    endfunction

    // keep pattern with cnt ones starting at the MSB
    function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input logic [TOT_WD-1:0] cnt);
        logic [DATA_BYTE_WD-1:0] k;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            k[DATA_BYTE_WD-1-i] = (TOT_WD'(i) < cnt);
        end
        return k;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    state_t                  state_r, next_state_s;
    logic [BYTE_CNT_WD:0]    s_r;
    logic [DATA_WD-1:0]      residue_r;      // MSB-aligned leftover bytes
    logic [TOT_WD-1:0]       res_cnt_r;      // valid bytes in residue_r

    logic [DATA_WD-1:0]      data_m_s;
    logic [TOT_WD-1:0]       n_s, m_s, r_s, total_s;
    logic [DATA_WD-1:0]      beat_s, res_s;
    logic [2*DATA_WD-1:0]    comb_wide_s;

    logic                    out_free_s, ready_in_s, ready_remove_s, s_ld_s, acc_s;
    logic                    emit_s, emit_last_s, res_ld_s;
    logic [DATA_WD-1:0]      emit_data_s, res_next_s;
    logic [DATA_BYTE_WD-1:0] emit_keep_s;
    logic [TOT_WD-1:0]       res_cnt_next_s;

    assign out_free_s   = !valid_out || ready_out;
    assign ready_in     = ready_in_s && !rst;
    assign ready_remove = ready_remove_s && !rst;
    assign acc_s        = valid_in && ready_in_s;

    // Byte concatenation of the residue with the (header-stripped) incoming beat
    always_comb begin
        data_m_s = data_in & byte_mask(keep_in);
        n_s      = popcount(keep_in);
        if (state_r == FIRST) begin
            // A shift of a full beat width yields zero, covering s=DATA_BYTE_WD
            beat_s = data_m_s << {s_r, 3'b000};
            m_s    = (n_s > TOT_WD'(s_r)) ? (n_s - TOT_WD'(s_r)) : {TOT_WD{1'b0}};
            r_s    = {TOT_WD{1'b0}};
            res_s  = {DATA_WD{1'b0}};
        end else begin
            beat_s = data_m_s;
            m_s    = n_s;
            r_s    = res_cnt_r;
            res_s  = residue_r;
        end
        comb_wide_s = {res_s, {DATA_WD{1'b0}}} | ({beat_s, {DATA_WD{1'b0}}} >> {r_s, 3'b000});
        total_s     = r_s + m_s;
    end

    // Next-state, handshake and emit decisions
    always_comb begin
        next_state_s   = state_r;
        ready_in_s     = 1'b0;
        ready_remove_s = 1'b0;
        s_ld_s         = 1'b0;
        emit_s         = 1'b0;
        emit_data_s    = {DATA_WD{1'b0}};
        emit_keep_s    = {DATA_BYTE_WD{1'b0}};
        emit_last_s    = 1'b0;
        res_ld_s       = 1'b0;
        res_next_s     = {DATA_WD{1'b0}};
        res_cnt_next_s = {TOT_WD{1'b0}};
        case (state_r)
            IDLE: begin
                ready_remove_s = 1'b1;
                if (valid_remove) begin
                    s_ld_s       = 1'b1;
                    next_state_s = FIRST;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FIRST, STREAM: begin
                ready_in_s = out_free_s;
                if (acc_s) begin
                    res_ld_s = 1'b1;
                    if (last_in) begin
                        if (total_s == {TOT_WD{1'b0}}) begin
                            next_state_s = IDLE;
                        end else if (total_s <= TOT_WD'(DATA_BYTE_WD)) begin
                            emit_s       = 1'b1;
                            emit_keep_s  = msb_keep(total_s);
                            emit_data_s  = comb_wide_s[2*DATA_WD-1 -: DATA_WD] & byte_mask(msb_keep(total_s));
                            emit_last_s  = 1'b1;
                            next_state_s = IDLE;
                        end else begin
                            emit_s         = 1'b1;
                            emit_keep_s    = {DATA_BYTE_WD{1'b1}};
                            emit_data_s    = comb_wide_s[2*DATA_WD-1 -: DATA_WD];
                            res_next_s     = comb_wide_s[DATA_WD-1:0];
                            res_cnt_next_s = total_s - TOT_WD'(DATA_BYTE_WD);
                            next_state_s   = FLUSH;
                        end
                    end else begin
                        if (total_s >= TOT_WD'(DATA_BYTE_WD)) begin
                            emit_s         = 1'b1;
                            emit_keep_s    = {DATA_BYTE_WD{1'b1}};
                            emit_data_s    = comb_wide_s[2*DATA_WD-1 -: DATA_WD];
                            res_next_s     = comb_wide_s[DATA_WD-1:0];
                            res_cnt_next_s = total_s - TOT_WD'(DATA_BYTE_WD);
                        end else begin
                            // Not enough bytes yet for a beat: hold them as residue
                            res_next_s     = comb_wide_s[2*DATA_WD-1 -: DATA_WD];
                            res_cnt_next_s = total_s;
                        end
                        next_state_s = STREAM;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            FLUSH: begin
                if (out_free_s) begin
                    emit_s       = 1'b1;
                    emit_keep_s  = msb_keep(res_cnt_r);
                    emit_data_s  = residue_r;
                    emit_last_s  = 1'b1;
                    res_ld_s     = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FLUSH;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Remove count, residue and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r       <= '0;
            residue_r <= '0;
            res_cnt_r <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            if (s_ld_s) begin
                s_r <= byte_remove_cnt;
            end
            if (res_ld_s) begin
                residue_r <= res_next_s;
                res_cnt_r <= res_cnt_next_s;
            end
            if (emit_s) begin
                valid_out <= 1'b1;
                data_out  <= emit_data_s;
                keep_out  <= emit_keep_s;
                last_out  <= emit_last_s;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef AXIS_REMOVE_HDR_CHECK_EN
    // Malformed keep detector: partial keep mid-packet, or non-contiguous/empty last keep
    always_ff @(posedge clk) begin
        if (rst) begin
            err_keep <= 1'b0;
        end else if (acc_s) begin
            err_keep <= last_in ? ((keep_in != msb_keep(n_s)) || (keep_in == {DATA_BYTE_WD{1'b0}}))
                                : (keep_in != {DATA_BYTE_WD{1'b1}});
        end else begin
            err_keep <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_remove_header.sv
module tb_axi_stream_remove_header;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_remove;
    logic [2:0]  byte_remove_cnt;
    logic        ready_remove;
`ifdef AXIS_REMOVE_HDR_CHECK_EN
    logic        err_keep;
`endif

    int tests = 0;
    int fails = 0;
    logic [36:0] outq[$];
    bit stall_en = 1'b0;

    always #5 clk = ~clk;

    axi_stream_remove_header dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt), .ready_remove(ready_remove)
`ifdef AXIS_REMOVE_HDR_CHECK_EN
        , .err_keep(err_keep)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records handshaken beats and checks stability under stall
    logic        stalled_prev = 1'b0;
    logic [36:0] prev_beat;
    always @(negedge clk) begin
        if (!rst && stalled_prev) begin
            chk("stall_valid", {63'd0, valid_out}, 64'd1);
            chk("stall_beat", {27'd0, last_out, keep_out, data_out}, {27'd0, prev_beat});
        end
        stalled_prev = !rst && valid_out && !ready_out;
        prev_beat = {last_out, keep_out, data_out};
        if (!rst && valid_out && ready_out) outq.push_back({last_out, keep_out, data_out});
    end

    // Downstream ready: random when stalling is enabled
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_out = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_remove(input logic [2:0] cnt);
        int k;
        @(posedge clk); #1;
        valid_remove = 1'b1;
        byte_remove_cnt = cnt;
        k = 0;
        @(negedge clk);
        while (!ready_remove && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("remove_hs", {63'd0, ready_remove}, 64'd1);
        @(posedge clk); #1;
        valid_remove = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
        int t;
        @(posedge clk); #1;
        repeat (gap) begin @(posedge clk); #1; end
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        t = 0;
        @(negedge clk);
        while (!ready_in && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("in_hs", {63'd0, ready_in}, 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (outq.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("out_count", 64'(outq.size()), 64'(n));
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        logic [36:0] e;
        if (outq.size() > 0) begin
            e = outq.pop_front();
            chk(tag, {27'd0, e}, {27'd0, l, k, d});
        end else begin
            chk({tag, "_present"}, 64'(outq.size()), 64'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_remove = 1'b0; byte_remove_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
        chk("rst_data_out", {32'd0, data_out}, 64'd0);
        chk("rst_keep_out", {60'd0, keep_out}, 64'd0);
        chk("rst_last_out", {63'd0, last_out}, 64'd0);
        chk("rst_ready_in", {63'd0, ready_in}, 64'd0);
        chk("rst_ready_remove", {63'd0, ready_remove}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_remove", {63'd0, ready_remove}, 64'd1);
        chk("idle_ready_in", {63'd0, ready_in}, 64'd0);

        // s=0: pass-through with 1 clk latency
        outq.delete();
        do_remove(3'd0);
        send_beat(32'h11223344, 4'b1111, 1'b0, 0);
        @(negedge clk);
        chk("s0_lat_valid", {63'd0, valid_out}, 64'd1);
        chk("s0_lat_data", {32'd0, data_out}, {32'd0, 32'h11223344});
        send_beat(32'h55660000, 4'b1100, 1'b1, 0);
        wait_out(2);
        expect_beat("s0_b0", 32'h11223344, 4'b1111, 1'b0);
        expect_beat("s0_b1", 32'h55660000, 4'b1100, 1'b1);

        // s=1: full beat then flush beat
        outq.delete();
        do_remove(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0, 0);
        @(negedge clk);
        chk("s1_no_early_out", {63'd0, valid_out}, 64'd0);
        send_beat(32'h11223344, 4'b1111, 1'b1, 0);
        @(negedge clk);
        chk("s1_lat_valid", {63'd0, valid_out}, 64'd1);
        chk("s1_lat_data", {32'd0, data_out}, {32'd0, 32'hBBCCDD11});
        wait_out(2);
        expect_beat("s1_b0", 32'hBBCCDD11, 4'b1111, 1'b0);
        expect_beat("s1_b1", 32'h22334400, 4'b1110, 1'b1);

        // s=3: merged single last beat
        outq.delete();
        do_remove(3'd3);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0, 0);
        send_beat(32'h11220000, 4'b1100, 1'b1, 0);
        wait_out(1);
        expect_beat("s3_b0", 32'hDD112200, 4'b1110, 1'b1);

        // s=4: whole first beat dropped
        outq.delete();
        do_remove(3'd4);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0, 0);
        send_beat(32'h11223344, 4'b1000, 1'b1, 0);
        wait_out(1);
        expect_beat("s4_b0", 32'h11000000, 4'b1000, 1'b1);

        // s=2 on a 2-byte single-beat packet: fully stripped
        outq.delete();
        do_remove(3'd2);
        send_beat(32'h99880000, 4'b1100, 1'b1, 0);
        @(negedge clk);
        chk("s2_ready_remove", {63'd0, ready_remove}, 64'd1);
        wait_out(0);

        // s=1 with random downstream stalls and gapped input
        outq.delete();
        stall_en = 1'b1;
        do_remove(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0, 2);
        send_beat(32'h11223344, 4'b1111, 1'b1, 3);
        wait_out(2);
        stall_en = 1'b0;
        expect_beat("stall_b0", 32'hBBCCDD11, 4'b1111, 1'b0);
        expect_beat("stall_b1", 32'h22334400, 4'b1110, 1'b1);
        repeat (3) @(posedge clk);

        // Reset mid-packet, then a clean s=0 packet
        outq.delete();
        do_remove(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_in", {63'd0, ready_in}, 64'd0);
        chk("mid_rst_ready_remove", {63'd0, ready_remove}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid_out", {63'd0, valid_out}, 64'd0);
        do_remove(3'd0);
        send_beat(32'hA1B2C3D4, 4'b1111, 1'b0, 0);
        send_beat(32'hE5F60000, 4'b1100, 1'b1, 0);
        wait_out(2);
        expect_beat("post_rst_b0", 32'hA1B2C3D4, 4'b1111, 1'b0);
        expect_beat("post_rst_b1", 32'hE5F60000, 4'b1100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
